// File: rtl/popcount_pkg.sv
// -----------------------------------------------------------------------------
// popcount_pkg
// Shared definitions for the popcount / unary datapath: frame geometry, the
// serializer state encoding and the helpers that define slot placement and the
// thermometer view of a count. The compressor round-trip bench imports the same
// helpers, so both directions agree on the encoding.
// -----------------------------------------------------------------------------
package popcount_pkg;

   localparam int SLOTS   = 15;  // beats per unary frame
   localparam int COUNT_W = 4;   // width of a popcount value 0..15
   localparam int SLOT_W  = 4;   // width of the slot index 0..14

   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } state_t;

   // Reverse the bit order of a 4-bit value. Applied to 1..15 this is a
   // permutation of 1..15, which is what makes the spread placement exact.
   function automatic logic [3:0] bitrev4(input logic [3:0] v);
      return {v[0], v[1], v[2], v[3]};
   endfunction

   // Thermometer code: bits [c-1:0] set, upper bits clear.
   function automatic logic [14:0] count_to_therm(input logic [3:0] c);
      logic [14:0] t;
      t = '0;
      for (int i = 0; i < 15; i++) begin
         t[i] = (4'(i) < c);
      end
      return t;
   endfunction

endpackage

// File: rtl/unary_slot_pattern.sv
// -----------------------------------------------------------------------------
// unary_slot_pattern
// Combinational placement rule: decides whether slot i_slot of a frame carrying
// i_count ones is a 1.
//   SPREAD = 0 : burst, slots 0..count-1 high
//   SPREAD = 1 : even spread, slot high when bitrev4(slot+1) <= count
// Ports:
//   i_count  popcount value 0..15
//   i_slot   slot index 0..14
//   o_bit    unary bit for that slot
// -----------------------------------------------------------------------------
module unary_slot_pattern
   import popcount_pkg::*;
#(
   parameter int SPREAD = 1
) (
   input  logic [COUNT_W-1:0] i_count,
   input  logic [SLOT_W-1:0]  i_slot,
   output logic               o_bit
);

   generate
      if (SPREAD != 0) begin : g_spread
         logic [SLOT_W-1:0] w_pos;

         // slot+1 never wraps because the slot index stops at 14.
         assign w_pos = bitrev4(i_slot + 4'd1);
         assign o_bit = (w_pos <= i_count);
      end else begin : g_burst
         assign o_bit = (i_slot < i_count);
      end
   endgenerate

endmodule

// File: rtl/popcount_unary_serializer.sv
// -----------------------------------------------------------------------------
// popcount_unary_serializer
// Accepts one 4-bit count per valid/ready handshake and re-expands it into a
// 15-beat unary frame in which exactly `count` beats are 1. Placement is burst
// or bit-reversed spread (SPREAD). Back-to-back frames run without a bubble:
// the next count is taken on the beat that completes slot 14.
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready    count handshake; in_ready is combinational from
//                        out_ready on the last beat of a frame
//   in_count             popcount value 0..15, sampled only on handshake
//   out_valid/out_ready  beat handshake
//   out_bit              unary bit of the current slot
//   out_first, out_last  current beat is slot 0 / slot 14
//   out_therm            thermometer code of the latched count
//   busy                 a frame is in progress
// -----------------------------------------------------------------------------
module popcount_unary_serializer #(
   parameter int SPREAD  = 1,
   parameter int SLOTS   = 15,
   parameter int COUNT_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [COUNT_W-1:0] in_count,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               out_bit,
   output logic               out_first,
   output logic               out_last,
   output logic [SLOTS-1:0]   out_therm,
   output logic               busy
);

   import popcount_pkg::*;

   generate
      if (SLOTS != 15 || COUNT_W != 4) begin : g_bad_geometry
         $error("popcount_unary_serializer supports only SLOTS=15, COUNT_W=4");
      end
   endgenerate

   localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SLOTS - 1);

   state_t               r_state;
   logic [SLOT_W-1:0]    r_slot;
   logic [COUNT_W-1:0]   r_count;

   state_t               w_next_state;
   logic [SLOT_W-1:0]    w_next_slot;
   logic [COUNT_W-1:0]   w_next_count;
   logic                 w_emit;
   logic                 w_beat;
   logic                 w_frame_end;
   logic                 w_take;
   logic                 w_pattern_bit;

   unary_slot_pattern #(
      .SPREAD (SPREAD)
   ) u_pattern (
      .i_count (r_count),
      .i_slot  (r_slot),
      .o_bit   (w_pattern_bit)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_slot  <= '0;
         r_count <= '0;
      end else begin
         r_state <= w_next_state;
         r_slot  <= w_next_slot;
         r_count <= w_next_count;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_next_slot  = r_slot;
      w_next_count = r_count;

      w_emit      = (r_state == EMIT);
      w_beat      = w_emit & out_ready;
      w_frame_end = w_beat & (r_slot == LAST_SLOT);
      // rst gates in_ready directly so it is low for the whole reset window,
      // not only after the asynchronous clear has propagated to r_state.
      in_ready    = ~rst & ((r_state == IDLE) | w_frame_end);
      w_take      = in_valid & in_ready;

      out_valid = w_emit;
      busy      = w_emit;
      out_bit   = w_emit & w_pattern_bit;
      out_first = w_emit & (r_slot == '0);
      out_last  = w_emit & (r_slot == LAST_SLOT);
      out_therm = count_to_therm(r_count);

      case (r_state)
         IDLE: begin
            if (w_take) begin
               w_next_state = EMIT;
               w_next_slot  = '0;
               w_next_count = in_count;
            end
         end
         EMIT: begin
            if (w_frame_end) begin
               w_next_slot = '0;
               if (w_take) begin
                  // Zero-bubble chaining: the next frame starts on the very
                  // next cycle with the freshly latched count.
                  w_next_count = in_count;
               end else begin
                  w_next_state = IDLE;
               end
            end else if (w_beat) begin
               w_next_slot = r_slot + 4'd1;
            end
         end
         default: begin
            w_next_state = IDLE;
            w_next_slot  = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_popcount_unary_serializer.sv
// -----------------------------------------------------------------------------
// tb_popcount_unary_serializer
// Two instances share all inputs: one with spread placement, one with burst
// placement. Stimulus pushes the expected 15 beats of each accepted frame into
// a queue; a monitor on the falling edge compares every valid cycle against the
// head of the queue and pops on accepted beats.
// -----------------------------------------------------------------------------
module tb_popcount_unary_serializer;

   typedef struct {
      logic        sbit;
      logic        bbit;
      logic        first;
      logic        last;
      logic [14:0] therm;
   } beat_t;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic [3:0]  in_count;
   logic        out_ready;

   logic        s_in_ready, s_out_valid, s_out_bit, s_out_first, s_out_last, s_busy;
   logic [14:0] s_out_therm;
   logic        b_in_ready, b_out_valid, b_out_bit, b_out_first, b_out_last, b_busy;
   logic [14:0] b_out_therm;

   beat_t q[$];
   int    n_checks;
   int    n_pass;
   int    popped;
   int    idle_cycles;
   bit    bp_en;

   popcount_unary_serializer #(.SPREAD(1), .SLOTS(15), .COUNT_W(4)) dut_s (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (s_in_ready),
      .in_count  (in_count),
      .out_valid (s_out_valid),
      .out_ready (out_ready),
      .out_bit   (s_out_bit),
      .out_first (s_out_first),
      .out_last  (s_out_last),
      .out_therm (s_out_therm),
      .busy      (s_busy)
   );

   popcount_unary_serializer #(.SPREAD(0), .SLOTS(15), .COUNT_W(4)) dut_b (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (b_in_ready),
      .in_count  (in_count),
      .out_valid (b_out_valid),
      .out_ready (out_ready),
      .out_bit   (b_out_bit),
      .out_first (b_out_first),
      .out_last  (b_out_last),
      .out_therm (b_out_therm),
      .busy      (b_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hand-derived spread frames, bit i = slot i. Slot order of bitrev4(slot+1):
   // 8,4,12,2,10,6,14,1,9,5,13,3,11,7,15.
   function automatic logic [14:0] spread_pat(input int c);
      case (c)
         0:       return 15'h0000;
         1:       return 15'h0080;
         2:       return 15'h0088;
         3:       return 15'h0888;
         5:       return 15'h0A8A;
         7:       return 15'h2AAA;
         8:       return 15'h2AAB;
         9:       return 15'h2BAB;
         10:      return 15'h2BBB;
         12:      return 15'h3BBF;
         15:      return 15'h7FFF;
         default: return 15'h0000;
      endcase
   endfunction

   // Burst frame and thermometer code coincide: low `c` bits set.
   function automatic logic [14:0] burst_pat(input int c);
      case (c)
         0:       return 15'h0000;
         1:       return 15'h0001;
         2:       return 15'h0003;
         3:       return 15'h0007;
         5:       return 15'h001F;
         7:       return 15'h007F;
         8:       return 15'h00FF;
         9:       return 15'h01FF;
         10:      return 15'h03FF;
         12:      return 15'h0FFF;
         15:      return 15'h7FFF;
         default: return 15'h0000;
      endcase
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push_frame(input int c);
      logic [14:0] sp;
      logic [14:0] bp;
      beat_t       b;
      sp = spread_pat(c);
      bp = burst_pat(c);
      for (int s = 0; s < 15; s++) begin
         b.sbit  = sp[s];
         b.bbit  = bp[s];
         b.first = (s == 0);
         b.last  = (s == 14);
         b.therm = bp;
         q.push_back(b);
      end
   endtask

   // Present a count and hold it until in_ready; keep leaves in_valid high so
   // the next call chains without a gap.
   task automatic send(input int c, input bit keep);
      int t;
      t = 0;
      in_valid = 1'b1;
      in_count = 4'(c);
      forever begin
         #1;
         if (s_in_ready) break;
         @(negedge clk);
         t++;
         if (t > 500) begin
            chk("send_timeout", 1, 0);
            in_valid = 1'b0;
            return;
         end
      end
      push_frame(c);
      @(posedge clk);
      #1;
      if (!keep) begin
         in_valid = 1'b0;
         in_count = 4'hE;  // ignored outside a handshake
      end
   endtask

   task automatic drain(input string name);
      int t;
      t = 0;
      while (q.size() != 0 && t < 2000) begin
         @(posedge clk);
         t++;
      end
      chk(name, q.size(), 0);
   endtask

   task automatic frame(input int c);
      int p0;
      @(negedge clk);
      p0 = popped;
      send(c, 1'b0);
      drain("frame_drain");
      chk("frame_beats", popped - p0, 15);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_s_in_ready"},  int'(s_in_ready),  0);
      chk({tag, "_s_out_valid"}, int'(s_out_valid), 0);
      chk({tag, "_s_out_bit"},   int'(s_out_bit),   0);
      chk({tag, "_s_first"},     int'(s_out_first), 0);
      chk({tag, "_s_last"},      int'(s_out_last),  0);
      chk({tag, "_s_therm"},     int'(s_out_therm), 0);
      chk({tag, "_s_busy"},      int'(s_busy),      0);
      chk({tag, "_b_in_ready"},  int'(b_in_ready),  0);
      chk({tag, "_b_out_valid"}, int'(b_out_valid), 0);
      chk({tag, "_b_therm"},     int'(b_out_therm), 0);
      chk({tag, "_b_busy"},      int'(b_busy),      0);
   endtask

   // Monitor: compare the head of the queue on every valid cycle, stalled or
   // not, so held outputs are checked against the same expected beat.
   always @(negedge clk) begin
      if (!rst) begin
         if (s_out_valid) begin
            if (q.size() == 0) begin
               chk("unexpected_beat", 1, 0);
            end else begin
               chk("bit_spread",  int'(s_out_bit),   int'(q[0].sbit));
               chk("bit_burst",   int'(b_out_bit),   int'(q[0].bbit));
               chk("first",       int'(s_out_first), int'(q[0].first));
               chk("last",        int'(s_out_last),  int'(q[0].last));
               chk("therm_s",     int'(s_out_therm), int'(q[0].therm));
               chk("therm_b",     int'(b_out_therm), int'(q[0].therm));
               chk("busy_emit",   int'(s_busy),      1);
               chk("b_out_valid", int'(b_out_valid), 1);
               chk("in_ready_emit", int'(s_in_ready), int'(q[0].last & out_ready));
               if (out_ready) begin
                  void'(q.pop_front());
                  popped++;
               end
            end
         end else begin
            idle_cycles++;
            chk("idle_busy",     int'(s_busy),      0);
            chk("idle_in_ready", int'(s_in_ready),  1);
            chk("idle_b_valid",  int'(b_out_valid), 0);
            chk("idle_out_bit",  int'(s_out_bit),   0);
         end
      end
   end

   always @(posedge clk) begin
      if (bp_en) begin
         #1;
         out_ready = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      int p0;
      int i0;
      n_checks    = 0;
      n_pass      = 0;
      popped      = 0;
      idle_cycles = 0;
      bp_en       = 1'b0;
      rst         = 1'b1;
      in_valid    = 1'b0;
      in_count    = 4'd0;
      out_ready   = 1'b1;

      #3;
      check_zero("reset");
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("post_reset_in_ready", int'(s_in_ready), 1);

      // Burst count 5 on dut_b, spread count 5 on dut_s.
      frame(5);
      // Spread placements and extremes.
      frame(1);
      frame(8);
      frame(0);
      frame(15);

      // Back-to-back: 3, 12, 7 with in_valid held high.
      @(negedge clk);
      p0 = popped;
      send(3, 1'b1);
      i0 = idle_cycles;
      send(12, 1'b1);
      send(7, 1'b0);
      drain("b2b_drain");
      chk("b2b_beats", popped - p0, 45);
      chk("b2b_no_bubble", idle_cycles - i0, 0);

      // Random backpressure on a count-9 frame.
      bp_en = 1'b1;
      frame(9);
      bp_en = 1'b0;
      @(posedge clk);
      #2;
      out_ready = 1'b1;

      // Asynchronous reset in the middle of a count-10 frame at slot 6.
      @(negedge clk);
      p0 = popped;
      send(10, 1'b0);
      for (int t = 0; t < 100 && popped < p0 + 6; t++) begin
         @(posedge clk);
      end
      chk("mid_slot6_reached", popped - p0, 6);
      #3;
      rst = 1'b1;
      #1;
      check_zero("mid_rst");
      q.delete();
      repeat (2) @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      chk("rel_in_ready", int'(s_in_ready), 1);
      chk("rel_busy", int'(s_busy), 0);
      frame(2);

      repeat (3) @(posedge clk);
      chk("final_queue_empty", q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/popcount_unary_serializer.md
Name: popcount_unary_serializer

Overview:
- Inverse-direction companion to the 15-to-4 popcount compressor in the binary CNN datapath.
- Accepts one 4-bit count (0..15) per valid/ready handshake.
- Re-expands the count into a 15-slot unary frame, one bit per output beat. Exactly `count` beats of the frame are 1.
- Slots are placed either as a burst or spread evenly by bit-reversed phase.
- Feeds spike/stochastic-style downstream lanes and the compressor round-trip checker.

Parameters:
- SPREAD, 1: 0 = burst placement, slots 0..count-1 high; 1 = bit-reversed even spread.
- SLOTS, 15: beats per frame; fixed at 15. Any other value is a elaboration error.
- COUNT_W, 4: width of the input count.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_count is valid.
- in_ready  output  1  block can accept a count this cycle.
- in_count  input  4  popcount value 0..15.
- out_valid  output  1  out_bit carries a frame beat.
- out_ready  input  1  downstream accepts the beat.
- out_bit  output  1  unary bit for the current slot.
- out_first  output  1  current beat is slot 0.
- out_last  output  1  current beat is slot 14.
- out_therm  output  15  thermometer code of the latched count, bits [count-1:0] = 1; held for the whole frame.
- busy  output  1  a frame is in progress.

Behaviour:
- Reset: all outputs are 0 while rst = 1. This includes in_ready, which is forced low during reset. State is IDLE, slot = 0, count register = 0.
- Reset mid-frame aborts the frame immediately. No completion beat is produced. After release, the block is IDLE with in_ready = 1.
- Reset is asynchronous on assertion. All registers clear without a clock edge.
- States:
  - IDLE: out_valid = 0, busy = 0, in_ready = 1. On in_valid & in_ready: latch in_count, set slot = 0, go to EMIT.
  - EMIT: out_valid = 1, busy = 1. On out_valid & out_ready: slot increments.
- Frame end: at slot 14, an accepted beat ends the frame.
  - If in_valid = 1 in that same cycle, the next count is latched and the block stays in EMIT with slot = 0. Back-to-back frames have zero bubble.
  - Otherwise the block returns to IDLE.
- in_ready = (state == IDLE) | (state == EMIT & slot == 14 & out_ready). This is a combinational path from out_ready. in_ready is never high while rst = 1.
- Backpressure: while out_ready = 0, out_bit, out_first, out_last, out_therm and slot hold stable. No beat is dropped or duplicated.
- Latency: count accepted at edge N gives first beat valid in cycle N+1. A frame is 15 accepted beats.
- Burst placement (SPREAD = 0): out_bit = (slot < count).
- Spread placement (SPREAD = 1):
  - p = bitrev4(slot + 1), with slot + 1 in 1..15; out_bit = (p <= count).
  - bitrev4 permutes 1..15, so exactly `count` ones appear per frame.
  - count = 0 gives all zeros; count = 15 gives all ones.
- Invariant: the sum of out_bit over a frame equals the latched count. out_therm popcount also equals the latched count.
- out_first = EMIT & slot == 0; out_last = EMIT & slot == 14.
- in_count is sampled only on handshake. Changes at other times have no effect.
- The slot counter never exceeds 14. There is no wrap inside a frame.

Decomposition:
- Shared package popcount_pkg:
  - SLOTS = 15, COUNT_W = 4, SLOT_W = 4.
  - State enum {IDLE, EMIT}.
  - Function bitrev4.
  - Function count_to_therm, 4 bits to 15 bits, reusable by the compressor bench.
- One sub-module: unary_slot_pattern. Combinational; maps (count, slot, SPREAD) to out_bit. Kept separate so the bench and any future parallel expander share the exact placement rule.
- FSM, handshake and counters live in the top.

Test Plan:
- Burst, out_ready = 1: count = 5 → out_bit 1,1,1,1,1 then 10 zeros. out_first on beat 0, out_last on beat 14, out_therm = 15'h001F for the whole frame.
- Spread: count = 1 → single 1 at slot 7 (bitrev(8) = 1). Count = 8 → ones at slots 0,1,3,5,7,9,11,13. Each frame sums to its count.
- Extremes: count = 0 → 15 zeros; count = 15 → 15 ones. out_valid high for exactly 15 accepted beats each.
- Back-to-back: in_valid held high with counts 3, 12, 7 and out_ready = 1 → 45 contiguous valid beats with no idle cycle. in_ready pulses only on slot-14 beats.
- Backpressure: count = 9, out_ready toggled randomly (50%) → stable outputs while stalled, frame sum = 9, exactly 15 accepted beats.
- Reset mid-frame: assert rst asynchronously at slot 6 of count = 10 → all outputs 0 immediately, no clock needed. After release, in_ready = 1 and the next count = 2 frame is correct from slot 0.
